// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix add/subtract engine.
// Holds the FSM state encoding, size/index helpers and element-count constants.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_ELEM_W  = 8;
    localparam int DEF_MAX_DIM = 5;
    localparam int DEF_LANES   = 5;
    localparam int MAX_ELEMS   = DEF_MAX_DIM * DEF_MAX_DIM;

    function automatic int max_elems(input int max_dim);
        return max_dim * max_dim;
    endfunction

    // size_sel encodes dim-2; anything beyond the largest supported size clamps.
    function automatic int size_to_dim(input int size_sel, input int max_dim);
        return (size_sel > max_dim - 2) ? max_dim : size_sel + 2;
    endfunction

    function automatic int elem_idx(input int base, input int lane);
        return base + lane;
    endfunction

    function automatic int n_steps(input int active, input int lanes);
        return (active + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/matrix_addsub_seq_if.sv
// Request/response bundle for matrix_addsub_seq: operands and control in,
// packed result plus status out.
interface matrix_addsub_seq_if #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int SZ_W    = $clog2(MAX_DIM - 1)
);
    localparam int N_ELEMS = MAX_DIM * MAX_DIM;

    logic                      start;
    logic                      op_sub;
    logic [SZ_W-1:0]           size_sel;
    logic [N_ELEMS*ELEM_W-1:0] matrix_a;
    logic [N_ELEMS*ELEM_W-1:0] matrix_b;
    logic                      busy;
    logic                      done;
    logic [N_ELEMS*ELEM_W-1:0] result_out;
    logic                      overflow;
    logic [N_ELEMS-1:0]        ovf_mask;

    modport master (
        output start, op_sub, size_sel, matrix_a, matrix_b,
        input  busy, done, result_out, overflow, ovf_mask
    );

    modport slave (
        input  start, op_sub, size_sel, matrix_a, matrix_b,
        output busy, done, result_out, overflow, ovf_mask
    );

endinterface

// File: rtl/matrix_lane_alu.sv
// Single-element signed add/subtract with overflow detect.
// Build option MATRIX_ADDSUB_SAT_EN saturates overflowing elements.
module matrix_lane_alu #(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic              op_sub,
    output logic [ELEM_W-1:0] res,
    output logic              ovf
);

    logic [ELEM_W:0] a_x;
    logic [ELEM_W:0] b_x;
    logic [ELEM_W:0] s;

    assign a_x = {a[ELEM_W-1], a};
    assign b_x = {b[ELEM_W-1], b};
    assign s   = op_sub ? (a_x - b_x) : (a_x + b_x);

    // Top two bits of the widened result disagree exactly when the operand
    // signs and the truncated result sign violate two's-complement rules.
    assign ovf = s[ELEM_W] ^ s[ELEM_W-1];

`ifdef MATRIX_ADDSUB_SAT_EN
    localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

    assign res = ovf ? (a[ELEM_W-1] ? SAT_MIN : SAT_MAX) : s[ELEM_W-1:0];
`else
    assign res = s[ELEM_W-1:0];
`endif

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential matrix add/subtract engine, LANES elements per RUN cycle.
// Optional saturation via MATRIX_ADDSUB_SAT_EN (inside matrix_lane_alu).
module matrix_addsub_seq
    import matrix_pkg::*;
#(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int LANES   = 5,
    parameter int SZ_W    = $clog2(MAX_DIM - 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_addsub_seq_if.slave  bus
);

    localparam int ME    = max_elems(MAX_DIM);
    localparam int AW    = $clog2(ME);
    localparam int IDX_W = $clog2(ME + LANES + 1);

    state_t              state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    active_reg;
    logic                op_sub_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [ELEM_W-1:0]   a_reg   [ME];
    logic [ELEM_W-1:0]   b_reg   [ME];
    logic [ELEM_W-1:0]   res_reg [ME];
    logic [ME-1:0]       ovf_reg;

    int                  dim_next;
    logic [IDX_W-1:0]    active_next;

    always_comb begin
        dim_next = size_to_dim(int'(bus.size_sel), MAX_DIM);
    end

    assign active_next = IDX_W'(dim_next * dim_next);

    logic [ELEM_W-1:0]   lane_a   [LANES];
    logic [ELEM_W-1:0]   lane_b   [LANES];
    logic [ELEM_W-1:0]   lane_res [LANES];
    logic                lane_ovf [LANES];
    logic                lane_en  [LANES];
    logic [IDX_W-1:0]    lane_e   [LANES];
    logic [AW-1:0]       lane_rd  [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_e[gi]  = IDX_W'(elem_idx(int'(idx_reg), gi));
            assign lane_en[gi] = (lane_e[gi] < active_reg);
            // Idle lanes read element 0 so the operand store is never over-addressed.
            assign lane_rd[gi] = lane_en[gi] ? AW'(lane_e[gi]) : '0;
            assign lane_a[gi]  = a_reg[lane_rd[gi]];
            assign lane_b[gi]  = b_reg[lane_rd[gi]];

            matrix_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
                .a      (lane_a[gi]),
                .b      (lane_b[gi]),
                .op_sub (op_sub_reg),
                .res    (lane_res[gi]),
                .ovf    (lane_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            active_reg <= '0;
            op_sub_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= '0;
            for (int i = 0; i < ME; i++) begin
                a_reg[i]   <= '0;
                b_reg[i]   <= '0;
                res_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < ME; i++) begin
                            a_reg[i]   <= bus.matrix_a[i*ELEM_W +: ELEM_W];
                            b_reg[i]   <= bus.matrix_b[i*ELEM_W +: ELEM_W];
                            res_reg[i] <= '0;
                        end
                        op_sub_reg <= bus.op_sub;
                        active_reg <= active_next;
                        idx_reg    <= '0;
                        ovf_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_en[k]) begin
                            res_reg[lane_rd[k]] <= lane_res[k];
                            ovf_reg[lane_rd[k]] <= lane_ovf[k];
                        end
                    end
                    idx_reg <= idx_reg + IDX_W'(LANES);
                    if (int'(idx_reg) + LANES >= int'(active_reg)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < ME; gi++) begin : g_pack
            assign bus.result_out[gi*ELEM_W +: ELEM_W] = res_reg[gi];
        end
    endgenerate

    assign bus.ovf_mask = ovf_reg;
    assign bus.overflow = |ovf_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Self-checking bench for matrix_addsub_seq: directed and random jobs against
// an integer-arithmetic reference model.
module tb_matrix_addsub_seq;

    localparam int EW    = 8;
    localparam int MD    = 5;
    localparam int LANES = 5;
    localparam int ME    = MD * MD;
    localparam int BW    = ME * EW;
    localparam int SZ_W  = $clog2(MD - 1);
    localparam int MAXV  = 2 ** (EW - 1) - 1;
    localparam int MINV  = -(2 ** (EW - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    matrix_addsub_seq_if #(.ELEM_W(EW), .MAX_DIM(MD)) bus ();

    matrix_addsub_seq #(.ELEM_W(EW), .MAX_DIM(MD), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] v;
        for (int i = 0; i < ME; i++) v[i*EW +: EW] = EW'($urandom);
        return v;
    endfunction

    // Plain integer arithmetic: anything outside the signed range is an overflow.
    function automatic void model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                  input logic op, input int sz,
                                  output logic [BW-1:0] res, output logic [ME-1:0] mask,
                                  output int n);
        int dim, active, av, bv, s;
        dim    = (sz > MD - 2) ? MD : sz + 2;
        active = dim * dim;
        n      = (active + LANES - 1) / LANES;
        res    = '0;
        mask   = '0;
        for (int i = 0; i < active; i++) begin
            av = $signed(a[i*EW +: EW]);
            bv = $signed(b[i*EW +: EW]);
            s  = op ? av - bv : av + bv;
            if (s > MAXV || s < MINV) begin
                mask[i] = 1'b1;
`ifdef MATRIX_ADDSUB_SAT_EN
                s = (s > MAXV) ? MAXV : MINV;
`endif
            end
            res[i*EW +: EW] = s[EW-1:0];
        end
    endfunction

    task automatic do_job(input string name, input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic op, input int sz, input bit hammer);
        logic [BW-1:0] er;
        logic [ME-1:0] em;
        int n, cyc;
        model(a, b, op, sz, er, em, n);
        @(negedge clk);
        bus.matrix_a = a;
        bus.matrix_b = b;
        bus.op_sub   = op;
        bus.size_sel = SZ_W'(sz);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = hammer;
        bus.matrix_a = rand_bus();
        bus.matrix_b = rand_bus();
        bus.op_sub   = ~op;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk({name, "_busy_run"}, BW'(bus.busy), BW'(1));
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, BW'(cyc), BW'(n + 1));
        chk({name, "_busy_done"}, BW'(bus.busy), BW'(1));
        chk({name, "_result"}, bus.result_out, er);
        chk({name, "_mask"}, BW'(bus.ovf_mask), BW'(em));
        chk({name, "_overflow"}, BW'(bus.overflow), BW'(|em));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, BW'(bus.done), BW'(0));
        chk({name, "_busy_idle"}, BW'(bus.busy), BW'(0));
        chk({name, "_result_hold"}, bus.result_out, er);
        $display("job %s op=%0d sz=%0d latency=%0d mask=%0h", name, op, sz, cyc, em);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] a, b, er;
        logic [ME-1:0] em;
        int n;
        bit seen_done;

        bus.start    = 1'b0;
        bus.op_sub   = 1'b0;
        bus.size_sel = '0;
        bus.matrix_a = '0;
        bus.matrix_b = '0;

        #12;
        chk("reset_busy", BW'(bus.busy), BW'(0));
        chk("reset_done", BW'(bus.done), BW'(0));
        chk("reset_overflow", BW'(bus.overflow), BW'(0));
        chk("reset_mask", BW'(bus.ovf_mask), BW'(0));
        chk("reset_result", bus.result_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2x2 add
        a = '0; b = '0;
        for (int i = 0; i < 4; i++) begin
            a[i*EW +: EW] = EW'(i + 1);
            b[i*EW +: EW] = EW'(10 * (i + 1));
        end
        do_job("add2x2", a, b, 1'b0, 0, 1'b0);
        chk("add2x2_literal", bus.result_out, BW'(32'h2c21160b));

        // 5x5 sub: 5 - 7 everywhere
        for (int i = 0; i < ME; i++) begin
            a[i*EW +: EW] = EW'(5);
            b[i*EW +: EW] = EW'(7);
        end
        do_job("sub5x5", a, b, 1'b1, 3, 1'b0);

        // 3x3 add with overflow in element 4
        a = '0; b = '0;
        for (int i = 0; i < 9; i++) begin
            a[i*EW +: EW] = EW'(i);
            b[i*EW +: EW] = EW'(2 * i);
        end
        a[4*EW +: EW] = EW'(100);
        b[4*EW +: EW] = EW'(100);
        do_job("ovf3x3", a, b, 1'b0, 1, 1'b0);
        chk("ovf3x3_mask_literal", BW'(bus.ovf_mask), BW'(25'h10));
`ifdef MATRIX_ADDSUB_SAT_EN
        chk("ovf3x3_elem4", BW'(bus.result_out[4*EW +: EW]), BW'(8'h7f));
`else
        chk("ovf3x3_elem4", BW'(bus.result_out[4*EW +: EW]), BW'(8'hc8));
`endif

        // Subtract overflow corners: -128-1 and 127-(-1)
        a = '0; b = '0;
        a[0*EW +: EW] = EW'(-128); b[0*EW +: EW] = EW'(1);
        a[1*EW +: EW] = EW'(127);  b[1*EW +: EW] = EW'(-1);
        a[2*EW +: EW] = EW'(-128); b[2*EW +: EW] = EW'(-128);
        a[3*EW +: EW] = EW'(-1);   b[3*EW +: EW] = EW'(127);
        do_job("subovf2x2", a, b, 1'b1, 0, 1'b0);

        // 4x4 with start held through RUN and DONE, then back-to-back 2x2
        do_job("hammer4x4", rand_bus(), rand_bus(), 1'b0, 2, 1'b1);
        do_job("b2b2x2", rand_bus(), rand_bus(), 1'b1, 0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            do_job($sformatf("rand%0d", t), rand_bus(), rand_bus(),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Abort a 5x5 job during its third RUN cycle
        a = rand_bus();
        b = rand_bus();
        model(a, b, 1'b0, 3, er, em, n);
        @(negedge clk);
        bus.matrix_a = a;
        bus.matrix_b = b;
        bus.op_sub   = 1'b0;
        bus.size_sel = SZ_W'(3);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", BW'(bus.busy), BW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", BW'(bus.busy), BW'(0));
        chk("abort_done", BW'(bus.done), BW'(0));
        chk("abort_result", bus.result_out, '0);
        chk("abort_mask", BW'(bus.ovf_mask), BW'(0));
        chk("abort_overflow", BW'(bus.overflow), BW'(0));
        #10 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", BW'(seen_done), BW'(0));
        chk("abort_idle_busy", BW'(bus.busy), BW'(0));
        $display("job abort5x5 reset in RUN cycle 3");

        do_job("after_abort", a, b, 1'b0, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
